// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------------------------
// alu_ctrl: instruction sequencer in front of an external combinational ALU.
//
// Each instruction passes through four states: IDLE -> READ -> EXEC -> WB.
// READ fetches the operands from a 16 x 16 register file into the registered alu_* outputs.
// EXEC samples the ALU result and flags. WB writes the result back.
// The block accepts one instruction every four cycles.
// wb_valid, wb_addr and wb_data are registered on the edge that leaves WB.
// With acceptance at edge N, wb_valid is therefore high in the cycle after edge N+3,
// which is the same cycle the next instruction can be accepted.
//
// Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt / shift amount.
// Ops 0..7 are legal; ops 8..15 are illegal.
//
// Configuration macro: ALU_CTRL_ILLEGAL_TRAP_EN
//   undefined : an illegal op pulses err for one cycle (in WB) and returns to IDLE.
//   defined   : an illegal op raises err and parks the FSM in HALT until rst.
//               While in HALT, instr_ready stays low and ld_valid is still honoured.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid, instr       instruction offer (held by the offerer until accepted)
//   instr_ready              high only in IDLE
//   ld_valid/addr/data       direct register-file load, any state; loses to a WB write
//   alu_opcode/src1/src2/shamt  registered ALU operands, stable from READ to next READ
//   alu_td, alu_psw          ALU result and flags {zero, overflow, sign}
//   wb_valid/addr/data       one-cycle write-back report
//   psw_q                    flags of the last completed legal instruction
//   err                      illegal-opcode indication
// ---------------------------------------------------------------------------------------------

module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        ld_valid,
    input  logic [3:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    output logic [3:0]  alu_shamt,
    input  logic [15:0] alu_td,
    input  logic [2:0]  alu_psw,
    output logic        wb_valid,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [2:0]  psw_q,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        StWb,
        StHalt
`else
        StWb
`endif
    } state_e;

    state_e      state_q;
    logic [15:0] instr_q;
    logic [15:0] result_q;
    logic [2:0]  flags_q;
    logic [15:0] rf [16];

    logic [3:0] op_f;
    logic [3:0] rd_f;
    logic [3:0] rs_f;
    logic [3:0] rt_f;
    logic       illegal_f;

    assign op_f      = instr_q[15:12];
    assign rd_f      = instr_q[11:8];
    assign rs_f      = instr_q[7:4];
    assign rt_f      = instr_q[3:0];
    // Opcodes 1xxx are outside the ALU's legal range.
    assign illegal_f = op_f[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            instr_ready <= 1'b1;
            alu_opcode  <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_shamt   <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            psw_q       <= '0;
            err         <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else begin
            wb_valid <= 1'b0;

            // Direct load comes first so a same-cycle WB write to the same register overrides it.
            // Register 0 is never written, so it always reads as zero.
            if (ld_valid && (ld_addr != 4'd0)) begin
                rf[ld_addr] <= ld_data;
            end

            case (state_q)
                StIdle: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state_q     <= StRead;
                    end
                end

                StRead: begin
                    alu_opcode <= op_f;
                    alu_src1   <= rf[rs_f];
                    alu_src2   <= rf[rt_f];
                    alu_shamt  <= rt_f;
                    state_q    <= StExec;
                end

                StExec: begin
                    result_q <= alu_td;
                    flags_q  <= alu_psw;
                    // err is high for the whole WB cycle of an illegal instruction.
                    err      <= illegal_f;
                    state_q  <= StWb;
                end

                StWb: begin
                    if (!illegal_f) begin
                        if (rd_f != 4'd0) begin
                            rf[rd_f] <= result_q;
                        end
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_f;
                        wb_data  <= result_q;
                        psw_q    <= flags_q;
                    end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    if (illegal_f) begin
                        // err stays high and instr_ready stays low until rst.
                        state_q <= StHalt;
                    end else begin
                        err         <= 1'b0;
                        instr_ready <= 1'b1;
                        state_q     <= StIdle;
                    end
`else
                    err         <= 1'b0;
                    instr_ready <= 1'b1;
                    state_q     <= StIdle;
`endif
                end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                StHalt: begin
                    err         <= 1'b1;
                    instr_ready <= 1'b0;
                    state_q     <= StHalt;
                end
`endif

                default: begin
                    err         <= 1'b0;
                    instr_ready <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed testbench for alu_ctrl. Provides a combinational ALU model on the alu_* interface.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic [3:0]  alu_shamt;
    logic [15:0] alu_td;
    logic [2:0]  alu_psw;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  psw_q;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_opcode  (alu_opcode),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_shamt   (alu_shamt),
        .alu_td      (alu_td),
        .alu_psw     (alu_psw),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .psw_q       (psw_q),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU: 0 and, 1 or, 2 xor, 3 not, 4 add, 5 sub, 6 shl, 7 shr; flags {zero, overflow, sign}.
    logic ov;
    always_comb begin
        alu_td = '0;
        ov     = 1'b0;
        case (alu_opcode)
            4'd0: alu_td = alu_src1 & alu_src2;
            4'd1: alu_td = alu_src1 | alu_src2;
            4'd2: alu_td = alu_src1 ^ alu_src2;
            4'd3: alu_td = ~alu_src1;
            4'd4: begin
                alu_td = alu_src1 + alu_src2;
                ov = (alu_src1[15] == alu_src2[15]) && (alu_td[15] != alu_src1[15]);
            end
            4'd5: begin
                alu_td = alu_src1 - alu_src2;
                ov = (alu_src1[15] != alu_src2[15]) && (alu_td[15] != alu_src1[15]);
            end
            4'd6: alu_td = alu_src1 << alu_shamt;
            4'd7: alu_td = alu_src1 >> alu_shamt;
            default: alu_td = '0;
        endcase
        alu_psw = {alu_td == 16'd0, ov, alu_td[15]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at a negedge.
    task automatic load(input logic [3:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] ins);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            errors++;
            $display("FAIL send_ready: instr_ready %b required 1 within 20 cycles", instr_ready);
        end
        instr_valid = 1'b1; instr = ins;
        @(negedge clk);
        instr_valid = 1'b0; instr = '0;
    endtask

    // Waits for wb_valid; lat = negedges after the accept edge, -1 on timeout.
    task automatic wait_wb(output int lat, output logic [3:0] a, output logic [15:0] d,
                           output logic [2:0] p);
        bit seen = 1'b0;
        lat = -1; a = 'x; d = 'x; p = 'x;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                seen = 1'b1; lat = i; a = wb_addr; d = wb_data; p = psw_q;
            end
        end
    endtask

    // Reads rf[r] through "or r0, r, r0"; returns the written-back value.
    task automatic read_reg(input logic [3:0] r, output logic [15:0] d);
        int lat; logic [3:0] a; logic [2:0] p;
        send({4'h1, 4'h0, r, 4'h0});
        wait_wb(lat, a, d, p);
    endtask

    task automatic test_reset;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b required 1", instr_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++;
            $display("FAIL reset_wb_valid: got %b required 0", wb_valid); end
        checks++; if (err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b required 0", err); end
        checks++; if (psw_q !== 3'b000) begin errors++;
            $display("FAIL reset_psw: got %b required 000", psw_q); end
        checks++;
        if ({alu_opcode, alu_src1, alu_src2, alu_shamt} !== 40'd0) begin errors++;
            $display("FAIL reset_alu: got %h %h %h %h required all 0",
                     alu_opcode, alu_src1, alu_src2, alu_shamt); end
    endtask

    task automatic test_add;
        int lat; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd1, 16'h00F0);
        load(4'd2, 16'h0F0F);
        send(16'h4312);
        wait_wb(lat, a, d, p);
        checks++; if (lat !== 3) begin errors++;
            $display("FAIL add_latency: got %0d required 3", lat); end
        checks++; if (a !== 4'd3) begin errors++;
            $display("FAIL add_addr: got %h required 3", a); end
        checks++; if (d !== 16'h0FFF) begin errors++;
            $display("FAIL add_data: got %h required 0fff", d); end
        checks++; if (p !== 3'b000) begin errors++;
            $display("FAIL add_psw: got %b required 000", p); end
        checks++; if ({alu_opcode, alu_shamt, alu_src1} !== {4'h4, 4'h2, 16'h00F0}) begin errors++;
            $display("FAIL add_alu_hold: got op %h shamt %h src1 %h required 4 2 00f0",
                     alu_opcode, alu_shamt, alu_src1); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++;
            $display("FAIL add_wb_pulse: got %b required 0", wb_valid); end
        read_reg(4'd3, d);
        checks++; if (d !== 16'h0FFF) begin errors++;
            $display("FAIL add_readback_r3: got %h required 0fff", d); end
    endtask

    task automatic test_overflow;
        int lat; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd1, 16'h7FFF);
        load(4'd2, 16'h0001);
        send(16'h4412);
        wait_wb(lat, a, d, p);
        checks++; if (d !== 16'h8000) begin errors++;
            $display("FAIL ovf_data: got %h required 8000", d); end
        checks++; if (p !== 3'b011) begin errors++;
            $display("FAIL ovf_psw: got %b required 011", p); end
    endtask

    task automatic test_r0;
        int lat; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd1, 16'h00F0);
        load(4'd2, 16'h0F0F);
        load(4'd0, 16'hBEEF);
        send(16'h0012);
        wait_wb(lat, a, d, p);
        checks++; if (lat !== 3 || a !== 4'd0) begin errors++;
            $display("FAIL r0_wb: got lat %0d addr %h required 3 0", lat, a); end
        checks++; if (p !== 3'b100) begin errors++;
            $display("FAIL r0_psw: got %b required 100", p); end
        send(16'h1000);
        wait_wb(lat, a, d, p);
        checks++; if (alu_src1 !== 16'h0000 || d !== 16'h0000) begin errors++;
            $display("FAIL r0_read: got src1 %h data %h required 0000 0000", alu_src1, d); end
    endtask

    task automatic test_back_to_back;
        int lat; int c0; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd1, 16'h0010);
        load(4'd2, 16'h0020);
        send(16'h4312);
        // Offer the dependent instruction immediately and hold it until accepted.
        instr_valid = 1'b1; instr = 16'h4431;
        wait_wb(lat, a, d, p);
        c0 = cyc;
        checks++; if (d !== 16'h0030) begin errors++;
            $display("FAIL b2b_first: got %h required 0030", d); end
        @(negedge clk);
        instr_valid = 1'b0; instr = '0;
        wait_wb(lat, a, d, p);
        checks++; if (a !== 4'd4 || d !== 16'h0040) begin errors++;
            $display("FAIL b2b_second: got addr %h data %h required 4 0040", a, d); end
        checks++; if (cyc - c0 !== 4) begin errors++;
            $display("FAIL b2b_throughput: got %0d cycles required 4", cyc - c0); end
    endtask

    task automatic test_illegal;
        int lat; int err_n; int wb_n; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd5, 16'h5555);
        send(16'h0000);
        wait_wb(lat, a, d, p);
        send(16'h9512);
        err_n = 0; wb_n = 0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (wb_valid) wb_n++;
            if (i >= 2 && err) err_n++;
            if (i == 5) begin instr_valid = 1'b1; instr = 16'h4312; end
        end
        instr_valid = 1'b0; instr = '0;
        checks++; if (err_n !== 9) begin errors++;
            $display("FAIL ill_err_held: got %0d high cycles required 9", err_n); end
        checks++; if (instr_ready !== 1'b0) begin errors++;
            $display("FAIL ill_halt_ready: got %b required 0", instr_ready); end
        checks++; if (wb_n !== 0 || psw_q !== 3'b100) begin errors++;
            $display("FAIL ill_no_wb: got wb %0d psw %b required 0 100", wb_n, psw_q); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (instr_ready !== 1'b1 || err !== 1'b0) begin errors++;
            $display("FAIL ill_rst_exit: got ready %b err %b required 1 0", instr_ready, err); end
        read_reg(4'd5, d);
        checks++; if (d !== 16'h0000) begin errors++;
            $display("FAIL ill_r5: got %h required 0000", d); end
`else
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (wb_valid) wb_n++;
            if (err) err_n++;
            if (i == 2) begin
                checks++; if (err !== 1'b1) begin errors++;
                    $display("FAIL ill_err_in_wb: got %b required 1", err); end
            end
            if (i == 3) begin
                checks++; if (instr_ready !== 1'b1) begin errors++;
                    $display("FAIL ill_ready_back: got %b required 1", instr_ready); end
            end
        end
        checks++; if (err_n !== 1) begin errors++;
            $display("FAIL ill_err_pulse: got %0d high cycles required 1", err_n); end
        checks++; if (wb_n !== 0 || psw_q !== 3'b100) begin errors++;
            $display("FAIL ill_no_wb: got wb %0d psw %b required 0 100", wb_n, psw_q); end
        read_reg(4'd5, d);
        checks++; if (d !== 16'h5555) begin errors++;
            $display("FAIL ill_r5: got %h required 5555", d); end
`endif
    endtask

    task automatic test_rst_mid;
        int wb_n; logic [15:0] d;
        load(4'd6, 16'h6666);
        send(16'h4612);
        @(negedge clk);
        // EXEC cycle: rst together with a load and an instruction offer.
        rst = 1'b1; ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 16'h7777;
        instr_valid = 1'b1; instr = 16'h4712;
        @(negedge clk);
        rst = 1'b0; ld_valid = 1'b0; instr_valid = 1'b0; instr = '0;
        checks++; if (instr_ready !== 1'b1 || psw_q !== 3'b000 || alu_src1 !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_state: got ready %b psw %b src1 %h required 1 000 0000",
                     instr_ready, psw_q, alu_src1); end
        wb_n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid) wb_n++;
        end
        checks++; if (wb_n !== 0) begin errors++;
            $display("FAIL rst_mid_no_wb: got %0d pulses required 0", wb_n); end
        read_reg(4'd6, d);
        checks++; if (d !== 16'h0000) begin errors++;
            $display("FAIL rst_mid_r6: got %h required 0000", d); end
        read_reg(4'd7, d);
        checks++; if (d !== 16'h0000) begin errors++;
            $display("FAIL rst_mid_r7: got %h required 0000", d); end
    endtask

    task automatic test_ld_collision;
        int lat; logic [3:0] a; logic [15:0] d; logic [2:0] p;
        load(4'd1, 16'h1230);
        load(4'd2, 16'h0004);
        send(16'h4312);
        @(negedge clk);
        @(negedge clk);
        // WB cycle: competing direct load to the same register.
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h1234) begin errors++;
            $display("FAIL coll_wb: got valid %b data %h required 1 1234", wb_valid, wb_data); end
        read_reg(4'd3, d);
        checks++; if (d !== 16'h1234) begin errors++;
            $display("FAIL coll_r3: got %h required 1234", d); end
        load(4'd3, 16'hAAAA);
        read_reg(4'd3, d);
        checks++; if (d !== 16'hAAAA) begin errors++;
            $display("FAIL ld_r3: got %h required aaaa", d); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_r0();
        test_back_to_back();
        test_illegal();
        test_rst_mid();
        test_ld_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 instr_valid  input  1  instruction offered this cycle.
REQ-004 instr  input  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt or shift amount.
REQ-005 instr_ready  output  1  controller can accept an instruction.
REQ-006 ld_valid, ld_addr[3:0], ld_data[15:0]  input  1/4/16  direct register-file load port.
REQ-007 alu_opcode  output  4  opcode driven to the ALU.
REQ-008 alu_src1, alu_src2  output  16 each  ALU operands.
REQ-009 alu_shamt  output  4  ALU shift amount.
REQ-010 alu_td  input  16  ALU result, combinational from alu_* outputs.
REQ-011 alu_psw  input  3  ALU flags {zero, overflow, sign}.
REQ-012 wb_valid  output  1  one-cycle pulse: result written back.
REQ-013 wb_addr, wb_data  output  4/16  written register and value, valid with wb_valid.
REQ-014 psw_q  output  3  flags of last completed legal instruction.
REQ-015 err  output  1  illegal-opcode indication.

Function
REQ-016 Register file: 16 x 16 bits; register 0 always reads 0, writes to it ignored (wb_valid still pulses).
REQ-017 FSM states IDLE, READ, EXEC, WB; only IDLE asserts instr_ready.
REQ-018 IDLE -> READ when instr_valid && instr_ready; instr captured into an internal register.
REQ-019 READ: alu_src1 <= rf[rs], alu_src2 <= rf[rt], alu_opcode <= op, alu_shamt <= instr[3:0]; -> EXEC.
REQ-020 EXEC: alu_td and alu_psw sampled into result/flag registers; -> WB.
REQ-021 WB: rf[rd] <= result, wb_valid = 1, wb_addr = rd, wb_data = result, psw_q <= flags; -> IDLE.
REQ-022 Latency: instruction accepted at edge N, wb_valid high in cycle after edge N+3; throughput 1 instruction per 4 cycles.
REQ-023 alu_* outputs registered and held constant from READ until next READ.
REQ-024 Legal ops 0000-0111; ops 1000-1111 illegal: no register write, no wb_valid, psw_q unchanged, err pulses one cycle in WB state.
REQ-025 Back-to-back: instruction N+1 reading rd of instruction N sees the written value (write completes before next READ).
REQ-026 ld_valid writes rf[ld_addr] <= ld_data in any state; same cycle and same address as WB write -> WB write wins.
REQ-027 instr_valid while not ready: ignored, no capture; offerer must hold until accepted.

Reset
REQ-028 rst: state IDLE, all 16 registers 0, instr_ready 1 in the following cycle, wb_valid 0, err 0, psw_q 000, alu_opcode/src1/src2/shamt 0.
REQ-029 rst asserted mid-instruction aborts it: no write-back, no wb_valid.
REQ-030 rst has priority over ld_valid and instr_valid in the same cycle.

Configuration
REQ-031 Macro ALU_CTRL_ILLEGAL_TRAP_EN defined: illegal opcode sets err and holds it high; FSM enters HALT, instr_ready stays 0 until rst; ld_valid still honoured.
REQ-032 Macro undefined: illegal opcode behaves per REQ-024 (one-cycle err pulse, returns to IDLE); no HALT state exists.

Verification
REQ-033 Load r1=0x00F0, r2=0x0F0F; instr 0x4312 (add r3=r1+r2) -> wb_valid 3 cycles after accept, wb_addr 3, wb_data 0x0FFF, psw_q from ALU.
REQ-034 Load r1=0x7FFF, r2=0x0001; instr 0x4412 -> wb_data 0x8000, psw_q[1]=1, psw_q[0]=1.
REQ-035 Instr 0x0012 (and into r0) -> wb_valid pulses, wb_addr 0, subsequent read of r0 as rs yields 0.
REQ-036 Instr 0x9512 -> no write to r5, err high; without macro err 1 cycle and instr_ready back; with macro instr_ready stays 0 until rst.
REQ-037 Accept instr, assert rst in EXEC -> no wb_valid, all registers 0, instr_ready 1 next cycle.
REQ-038 ld_valid to r3 with 0xAAAA same cycle as WB to r3 with 0x1234 -> r3 = 0x1234.
